// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lsu_pkg
// Summary  : Shared encodings for the load/store unit: access-size codes,
//            controller state encoding and the byte-enable lane helper.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Controller states; REQ1/WAIT1 only reachable when split beats are built
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    // True when byte 'lane' (relative to the access start) belongs to an
    // access of the given size; the byte-enable mask is built from this.
    function automatic logic be_lane(input logic [1:0] size, input int lane);
        return (lane >= 0) && (lane < (1 << size));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Summary  : Combinational load extract. Concatenates the two memory beats,
//            shifts the accessed bytes down to bit 0, truncates to the access
//            size and zero- or sign-extends to XLEN.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             i_beat0,
    input  logic [XLEN-1:0]             i_beat1,
    input  logic [$clog2(XLEN/8)-1:0]   i_offset,
    input  logic [1:0]                  i_size,
    input  logic                        i_signext,
    output logic [XLEN-1:0]             o_data
);

    logic [XLEN-1:0] w_low;
    logic            w_sign;
    int              w_width;

    // Shift, pick the sign bit of the accessed size, then extend above it
    always_comb begin
        w_low   = XLEN'({i_beat1, i_beat0} >> {i_offset, 3'b000});
        w_sign  = 1'b0;
        w_width = 8 << i_size;
        o_data  = '0;
        case (i_size)
            SZ_B:    w_sign = w_low[7];
            SZ_H:    w_sign = w_low[15];
            SZ_W:    w_sign = w_low[31];
            default: w_sign = w_low[XLEN-1];
        endcase
        for (int i = 0; i < XLEN; i++) begin
            o_data[i] = (i < w_width) ? w_low[i] : (i_signext & w_sign);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Summary  : Single-outstanding load/store controller between the EX/MEM
//            register and the data-memory port. Runs a req/gnt/rvalid
//            handshake, builds byte enables and lane-steered store data, and
//            returns extended load data one registered cycle after RESP.
// Config   : LSU_MISALIGN_SPLIT_EN - when defined, accesses crossing an
//            NBYTES boundary are issued as two beats; when undefined they are
//            answered immediately with resp_err=1 and never reach memory.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signext,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 resp_valid,
    output logic [XLEN-1:0]      resp_data,
    output logic                 resp_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN/8-1:0]    mem_be,
    output logic [XLEN-1:0]      mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata
);

    localparam int             NBYTES   = XLEN / 8;
    localparam int             c_off_w  = $clog2(NBYTES);
    localparam logic [c_off_w:0] c_nbytes = (c_off_w+1)'(NBYTES);

    lsu_state_e               r_state, w_next;
    logic                     r_we, r_signext;
    logic [1:0]               r_size;
    logic [ADDR_W-1:0]        r_addr;
    logic [XLEN-1:0]          r_wdata, r_beat0, w_beat1;
    logic                     r_resp_valid, r_resp_err;
    logic [XLEN-1:0]          r_resp_data;

    logic [1:0]               w_in_size;
    logic [c_off_w:0]         w_in_len;
    logic                     w_in_cross;
    logic [c_off_w-1:0]       w_off;
    logic [2*NBYTES-1:0]      w_be_wide;
    logic [2*XLEN-1:0]        w_wdata_wide;
    logic [ADDR_W-1:0]        w_line_addr;
    logic                     w_in_req, w_hi_beat, w_err;
    logic [XLEN-1:0]          w_load_data;

    // A dword request on a 32-bit datapath is handled as a word
    assign w_in_size  = (XLEN == 32 && req_size == SZ_D) ? SZ_W : req_size;
    assign w_in_len   = {{c_off_w{1'b0}}, 1'b1} << w_in_size;
    assign w_in_cross = ({1'b0, req_addr[c_off_w-1:0]} + w_in_len) > c_nbytes;

    assign w_off       = r_addr[c_off_w-1:0];
    assign w_line_addr = {r_addr[ADDR_W-1:c_off_w], {c_off_w{1'b0}}};
    assign w_in_req    = (r_state == REQ0) || (r_state == REQ1);

    // Byte enables over two lane windows: low half is beat 0, high half beat 1
    always_comb begin
        w_be_wide = '0;
        for (int i = 0; i < 2*NBYTES; i++) begin
            w_be_wide[i] = be_lane(r_size, i - int'(w_off));
        end
    end

    assign w_wdata_wide = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic            r_two_beat;
    logic [XLEN-1:0] r_beat1;

    assign w_hi_beat = (r_state == REQ1);
    assign w_beat1   = r_beat1;
    assign w_err     = 1'b0;

    // Remember whether a second beat is needed and capture its read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_two_beat <= 1'b0;
            r_beat1    <= '0;
        end else begin
            if (r_state == IDLE && req_valid) r_two_beat <= w_in_cross;
            if (r_state == WAIT1 && mem_rvalid) r_beat1 <= mem_rdata;
        end
    end
`else
    logic r_err;

    assign w_hi_beat = 1'b0;
    assign w_beat1   = '0;
    assign w_err     = r_err;

    // A boundary-crossing access is flagged at acceptance and never issued
    always_ff @(posedge clk) begin
        if (rst)                          r_err <= 1'b0;
        else if (r_state == IDLE && req_valid) r_err <= w_in_cross;
    end
`endif

    // Next-state logic; stray gnt/rvalid in other states fall through unused
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    w_next = REQ0;
`else
                    w_next = w_in_cross ? RESP : REQ0;
`endif
                end
            end
            REQ0:  if (mem_gnt) w_next = WAIT0;
            WAIT0: begin
                if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    w_next = r_two_beat ? REQ1 : RESP;
`else
                    w_next = RESP;
`endif
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ1:  if (mem_gnt) w_next = WAIT1;
            WAIT1: if (mem_rvalid) w_next = RESP;
`endif
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, request capture, beat-0 capture and the registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= SZ_B;
            r_signext    <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_beat0      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_we      <= req_we;
                r_size    <= w_in_size;
                r_signext <= req_signext;
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
            end
            if (r_state == WAIT0 && mem_rvalid) r_beat0 <= mem_rdata;
            r_resp_valid <= (r_state == RESP);
            r_resp_err   <= (r_state == RESP) && w_err;
            r_resp_data  <= (r_state == RESP && !r_we && !w_err) ? w_load_data : '0;
        end
    end

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_beat0   (r_beat0),
        .i_beat1   (w_beat1),
        .i_offset  (w_off),
        .i_size    (r_size),
        .i_signext (r_signext),
        .o_data    (w_load_data)
    );

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign mem_req    = w_in_req;
    assign mem_we     = w_in_req & r_we;
    assign mem_addr   = !w_in_req ? '0 :
                        (w_hi_beat ? w_line_addr + ADDR_W'(NBYTES) : w_line_addr);
    assign mem_be     = !w_in_req ? '0 :
                        (w_hi_beat ? w_be_wide[2*NBYTES-1:NBYTES] : w_be_wide[NBYTES-1:0]);
    assign mem_wdata  = !w_in_req ? '0 :
                        (w_hi_beat ? w_wdata_wide[2*XLEN-1:XLEN] : w_wdata_wide[XLEN-1:0]);

endmodule
`default_nettype wire
